// File: rtl/scope_trace_buffer.sv
// scope_trace_buffer: triggered single-trace capture into a double-buffered RAM,
// rendered as a 1-bit trace overlay for the pixel pipeline.
module scope_trace_buffer #(
    parameter int TRACE_LEN    = 640,
    parameter int Y_OFFSET     = 112,
    parameter int AUTO_TIMEOUT = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic       read_busy,
    input  logic [7:0] trig_level,
    input  logic       trig_rising,
    input  logic       frame_start,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       display_en,
    output logic       pixel_on,
    output logic       triggered
);
    localparam int AW = $clog2(TRACE_LEN);
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [9:0] LEN10 = 10'(TRACE_LEN);
    localparam logic [9:0] Y_BASE = 10'(Y_OFFSET + 255);
    typedef enum logic [1:0] {ARMED, CAPTURE, DONE} state_t;
    state_t state, state_nx;
    logic [AW-1:0] wr_addr, wr_addr_nx, we_addr, rd_addr;
    logic [TW-1:0] tmo_cnt;
    logic [7:0] prev_sample, prev_nx, rd_data;
    logic [7:0] ram [2][TRACE_LEN];
    logic display_bank, bank_nx, trig_nx, we, hit, tmo;
    logic [9:0] y_d;
    logic en_d, x_ok_d;

    assign hit = trig_rising ? (prev_sample < trig_level && sample_in >= trig_level)
                             : (prev_sample >= trig_level && sample_in < trig_level);
    assign tmo = tmo_cnt == TW'(AUTO_TIMEOUT - 1);
    assign read_busy = state == DONE;

    always_comb begin
        state_nx   = state;
        wr_addr_nx = wr_addr;
        prev_nx    = prev_sample;
        bank_nx    = display_bank;
        trig_nx    = triggered;
        we         = 1'b0;
        we_addr    = wr_addr;
        case (state)
            ARMED: begin
                prev_nx = sample_valid ? sample_in : prev_sample;
                if (sample_valid && hit) begin
                    we         = 1'b1;
                    we_addr    = '0;
                    wr_addr_nx = AW'(1);
                    trig_nx    = 1'b1;
                    state_nx   = CAPTURE;
                end else if (tmo) begin
                    wr_addr_nx = '0;
                    trig_nx    = 1'b0;
                    state_nx   = CAPTURE;
                end
            end
            CAPTURE: if (sample_valid) begin
                we         = 1'b1;
                wr_addr_nx = wr_addr + 1'b1;
                state_nx   = (wr_addr == AW'(TRACE_LEN - 1)) ? DONE : CAPTURE;
            end
            default: if (frame_start) begin
                bank_nx  = ~display_bank;
                prev_nx  = trig_level;
                state_nx = ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ARMED;
            wr_addr      <= '0;
            tmo_cnt      <= '0;
            prev_sample  <= '0;
            display_bank <= 1'b0;
            triggered    <= 1'b0;
        end else begin
            state        <= state_nx;
            wr_addr      <= wr_addr_nx;
            tmo_cnt      <= (state == ARMED && state_nx == ARMED) ? tmo_cnt + 1'b1 : '0;
            prev_sample  <= prev_nx;
            display_bank <= bank_nx;
            triggered    <= trig_nx;
        end
    end

    // Writes always target the back bank, so the shown trace cannot tear.
    always_ff @(posedge clk)
        if (we) ram[~display_bank][we_addr] <= sample_in;

    assign rd_addr = (pixel_x < LEN10) ? AW'(pixel_x) : '0;

    always_ff @(posedge clk)
        rd_data <= ram[display_bank][rd_addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_d      <= '0;
            en_d     <= 1'b0;
            x_ok_d   <= 1'b0;
            pixel_on <= 1'b0;
        end else begin
            y_d      <= pixel_y;
            en_d     <= display_en;
            x_ok_d   <= pixel_x < LEN10;
            pixel_on <= en_d && x_ok_d && (y_d == Y_BASE - {2'b00, rd_data});
        end
    end
endmodule

// File: tb/tb_scope_trace_buffer.sv
// tb_scope_trace_buffer: randomized stimulus against a queue/array model of
// capture, bank swapping and trace rendering, plus literal pixel pins.
module tb_scope_trace_buffer;
    localparam int LEN = 640, YOFF = 112, TMO = 100, YB = YOFF + 255;
    localparam int P_ARMED = 0, P_CAP = 1, P_DONE = 2;
    localparam int PX_SCAN = 0, PX_DIRECT = 1;

    logic clk = 1'b0, reset = 1'b0;
    logic [7:0] sample_in = '0, trig_level = 8'd128;
    logic sample_valid = 1'b0, trig_rising = 1'b1, frame_start = 1'b0, display_en = 1'b0;
    logic [9:0] pixel_x = '0, pixel_y = '0;
    logic read_busy, pixel_on, triggered;
    int checks = 0, failures = 0;

    scope_trace_buffer #(.TRACE_LEN(LEN), .Y_OFFSET(YOFF), .AUTO_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
        .read_busy(read_busy), .trig_level(trig_level), .trig_rising(trig_rising),
        .frame_start(frame_start), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .display_en(display_en), .pixel_on(pixel_on), .triggered(triggered)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model: phase, captured-sample queue, and both RAM banks as plain arrays.
    int m_phase, m_armed_cycles, m_prev;
    bit m_disp, m_trig, m_hit, on_screen;
    int m_ram [2][LEN];
    bit m_known [2][LEN];
    int m_trace[$];
    bit ex1_k, ex1_v, ex2_k, ex2_v;

    task automatic store(input int s);
        m_ram[!m_disp][m_trace.size()] = s;
        m_known[!m_disp][m_trace.size()] = 1'b1;
        m_trace.push_back(s);
        if (m_trace.size() == LEN) m_phase = P_DONE;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = P_ARMED;
            m_armed_cycles = 0;
            m_prev = 0;
            m_disp = 1'b0;
            m_trig = 1'b0;
            m_trace.delete();
            ex1_k = 1'b1; ex1_v = 1'b0; ex2_k = 1'b1; ex2_v = 1'b0;
        end else begin
            on_screen = display_en && pixel_x < LEN;
            ex2_k = ex1_k;
            ex2_v = ex1_v;
            ex1_k = !on_screen || m_known[m_disp][pixel_x];
            ex1_v = on_screen && m_known[m_disp][pixel_x] && (int'(pixel_y) == YB - m_ram[m_disp][pixel_x]);
            if (m_phase == P_ARMED) begin
                m_hit = sample_valid && (trig_rising ? (m_prev < int'(trig_level) && int'(sample_in) >= int'(trig_level))
                                                     : (m_prev >= int'(trig_level) && int'(sample_in) < int'(trig_level)));
                if (sample_valid) m_prev = int'(sample_in);
                if (m_hit) begin
                    m_trig = 1'b1;
                    m_phase = P_CAP;
                    store(int'(sample_in));
                end else if (m_armed_cycles == TMO - 1) begin
                    m_trig = 1'b0;
                    m_phase = P_CAP;
                end else m_armed_cycles++;
            end else if (m_phase == P_CAP) begin
                if (sample_valid) store(int'(sample_in));
            end else if (frame_start) begin
                m_disp = !m_disp;
                m_prev = int'(trig_level);
                m_phase = P_ARMED;
                m_armed_cycles = 0;
                m_trace.delete();
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset) begin
            check("read_busy", read_busy, m_phase == P_DONE);
            check("triggered", triggered, m_trig);
            if (ex2_k) check("pixel_on", pixel_on, ex2_v);
        end
    end

    // Pixel driver: sweeps each column at its trace row and one row below, plus random probes.
    int px_mode = PX_SCAN, scan_idx = 0, sx, srow;
    initial forever begin
        @(negedge clk);
        if (px_mode == PX_SCAN) begin
            sx = (scan_idx % 3 == 2) ? int'($urandom_range(0, 1023)) : scan_idx / 3;
            srow = (sx < LEN && m_known[m_disp][sx]) ? YB - m_ram[m_disp][sx] : int'($urandom_range(0, 479));
            pixel_x = 10'(sx);
            pixel_y = 10'(srow + ((scan_idx % 3 == 1) ? 1 : 0));
            display_en = (scan_idx % 3 == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            scan_idx = (scan_idx + 1) % (3 * LEN);
        end
    end

    function automatic logic [7:0] sample_for(input int kind, input int base, input int n);
        if (kind == 0) return 8'((base + n) % 256);
        if (kind == 1) return 8'(base);
        if (n == 0) return 8'd10;
        if (n == 1) return 8'd200;
        if (n == 11) return 8'd0;
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic run_stream(input int kind, input int base, input int gap, input int max_n);
        int n = 0, t = 0;
        px_mode = PX_SCAN;
        forever begin
            @(negedge clk);
            if (m_phase == P_DONE || n >= max_n || t > 20000) break;
            t++;
            sample_valid = (t % gap == 0);
            if (sample_valid) begin
                sample_in = sample_for(kind, base, n);
                n++;
            end
            frame_start = ($urandom_range(0, 199) == 0);
        end
        sample_valid = 1'b0;
        frame_start = 1'b0;
        check("stream_bound", t <= 20000, 1);
    endtask

    task automatic hold_done(input int cycles);
        repeat (cycles) begin
            @(negedge clk);
            sample_valid = 1'($urandom_range(0, 1));
            sample_in = 8'($urandom);
        end
        @(negedge clk);
        sample_valid = 1'b0;
        check("done_busy", read_busy, 1);
    endtask

    task automatic swap();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("swap_busy", read_busy, 0);
    endtask

    task automatic pix(input string name, input int x, input int y, input bit en, input bit want);
        px_mode = PX_DIRECT;
        @(negedge clk);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        display_en = en;
        @(negedge clk);
        @(negedge clk);
        check(name, pixel_on, want);
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < LEN; a++) m_known[b][a] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", read_busy, 0);
        check("rst_pix", pixel_on, 0);
        check("rst_trig", triggered, 0);
        #2 reset = 1'b1;
        // A: ramp through the rising threshold; 128 lands at address 0
        run_stream(0, 120, 4, LEN + 20);
        check("a_trig", triggered, 1);
        hold_done(40);
        swap();
        // B: DC below threshold, capture forced by the timeout
        run_stream(1, 50, 3, LEN + 60);
        check("b_trig", triggered, 0);
        hold_done(200);
        pix("a_addr0", 0, YB - 128, 1, 1);
        pix("a_addr1", 1, YB - 129, 1, 1);
        pix("a_row_off", 0, YB - 127, 1, 0);
        // swap lands exactly at frame_start: old bank read on that edge, new one after
        px_mode = PX_DIRECT;
        @(negedge clk);
        pixel_x = 10'd0;
        pixel_y = 10'(YB - 128);
        display_en = 1'b1;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
        check("swap_old_bank", pixel_on, 1);
        @(negedge clk);
        check("swap_new_bank", pixel_on, 0);
        // C: real trigger with sample 0 at column 10
        run_stream(2, 0, 3, LEN + 20);
        check("c_trig", triggered, 1);
        hold_done(30);
        swap();
        pix("c_col10", 10, 367, 1, 1);
        pix("c_col10_above", 10, 366, 1, 0);
        pix("c_addr0", 0, YB - 200, 1, 1);
        pix("x700", 700, 367, 1, 0);
        pix("en_off", 10, 367, 0, 0);
        // D: abandoned by reset at capture address 300
        run_stream(2, 0, 3, 301);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_busy", read_busy, 0);
        check("mid_rst_pix", pixel_on, 0);
        check("mid_rst_trig", triggered, 0);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        // E: fresh capture after reset, then switch to falling trigger for F
        run_stream(2, 0, 3, LEN + 20);
        check("e_trig", triggered, 1);
        hold_done(20);
        trig_rising = 1'b0;
        swap();
        pix("e_addr0", 0, YB - 200, 1, 1);
        pix("e_col10", 10, 367, 1, 1);
        run_stream(2, 0, 3, LEN + 20);
        check("f_trig", triggered, 1);
        hold_done(20);
        swap();
        pix("f_addr0", 0, YB - 10, 1, 1);
        px_mode = PX_SCAN;
        repeat (3 * LEN + 10) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL watchdog: got timeout, want end of sequence");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
